// File: rtl/sdram_frame_arb_if.sv
// -----------------------------------------------------------------------------
// sdram_frame_arb_if
// Burst handshake bundle between the frame arbiter and the SDRAM controller.
//   wr_sdram_req / wr_sdram_ack / wr_sdram_add : write burst request, ack, address
//   rd_sdram_req / rd_sdram_ack / rd_sdram_add : read burst request, ack, address
// Modports:
//   master : the arbiter (drives req/add, receives ack)
//   slave  : the SDRAM controller (receives req/add, drives ack)
// -----------------------------------------------------------------------------
interface sdram_frame_arb_if;
   logic        wr_sdram_req;
   logic        wr_sdram_ack;
   logic [23:0] wr_sdram_add;
   logic        rd_sdram_req;
   logic        rd_sdram_ack;
   logic [23:0] rd_sdram_add;

   modport master (
      output wr_sdram_req, wr_sdram_add, rd_sdram_req, rd_sdram_add,
      input  wr_sdram_ack, rd_sdram_ack
   );

   modport slave (
      input  wr_sdram_req, wr_sdram_add, rd_sdram_req, rd_sdram_add,
      output wr_sdram_ack, rd_sdram_ack
   );
endinterface

// File: rtl/sdram_frame_arb.sv
// -----------------------------------------------------------------------------
// sdram_frame_arb
// Arbitrates one SDRAM port between a camera write stream and a VGA read
// stream, each moving 512-word blocks, with double-buffered frame banks.
// Ports:
//   clk_133M_i      : clock, all logic on the rising edge
//   rst_133i        : asynchronous active-low reset
//   wr_fifo_used    : camera FIFO fill level
//   rd_fifo_used    : VGA FIFO fill level
//   cam_frame_start : one-cycle camera frame start pulse
//   vga_frame_start : one-cycle VGA frame start pulse
//   bus             : burst handshake (master side), see sdram_frame_arb_if
//   frame_ready     : at least one complete frame is stored
//   wr_bank/rd_bank : current write / read frame buffer
//   timeout_err     : sticky, an ack failed to arrive within TMO_CYC cycles
// -----------------------------------------------------------------------------
module sdram_frame_arb #(
   parameter int unsigned ROWS_PER_FRAME = 1440,
   parameter int unsigned WR_THRESH      = 512,
   parameter int unsigned RD_THRESH      = 512,
   parameter int unsigned WR_URGENT      = 1536,
   parameter int unsigned TMO_CYC        = 4095
) (
   input  logic                     clk_133M_i,
   input  logic                     rst_133i,
   input  logic [10:0]              wr_fifo_used,
   input  logic [10:0]              rd_fifo_used,
   input  logic                     cam_frame_start,
   input  logic                     vga_frame_start,
   sdram_frame_arb_if.master        bus,
   output logic                     frame_ready,
   output logic                     wr_bank,
   output logic                     rd_bank,
   output logic                     timeout_err
);

   localparam int unsigned TMO_W      = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TMO_CYC - 1);
   localparam logic [12:0]      ROWS_L    = 13'(ROWS_PER_FRAME);
   localparam logic [10:0]      WR_THR_L  = 11'(WR_THRESH);
   localparam logic [10:0]      RD_THR_L  = 11'(RD_THRESH);
   localparam logic [10:0]      WR_URG_L  = 11'(WR_URGENT);

   typedef enum logic [1:0] {IDLE, WR_BUSY, RD_BUSY} state_t;

   state_t           state_q, state_d;
   logic [12:0]      wr_blk_q, wr_blk_d;
   logic [12:0]      rd_blk_q, rd_blk_d;
   logic             wr_bank_q, wr_bank_d;
   logic             rd_bank_q, rd_bank_d;
   logic             full_bank_q, full_bank_d;
   logic             frame_ready_q, frame_ready_d;
   logic             timeout_q, timeout_d;
   logic             cam_pend_q, cam_pend_d;
   logic             vga_pend_q, vga_pend_d;
   logic             last_rd_q, last_rd_d;     // 1: last grant went to read
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             wr_req_q, wr_req_d;
   logic             rd_req_q, rd_req_d;
   logic [23:0]      wr_add_q, wr_add_d;
   logic [23:0]      rd_add_q, rd_add_d;

   logic wr_elig, rd_elig, wr_urgent;

   assign wr_elig   = (wr_fifo_used >= WR_THR_L) && (wr_blk_q < ROWS_L);
   assign rd_elig   = frame_ready_q && (rd_fifo_used <= RD_THR_L) && (rd_blk_q < ROWS_L);
   assign wr_urgent = (wr_fifo_used >= WR_URG_L);

   always_comb begin
      state_d       = state_q;
      wr_blk_d      = wr_blk_q;
      rd_blk_d      = rd_blk_q;
      wr_bank_d     = wr_bank_q;
      rd_bank_d     = rd_bank_q;
      full_bank_d   = full_bank_q;
      frame_ready_d = frame_ready_q;
      timeout_d     = timeout_q;
      // Start pulses are captured in any state so none is lost mid-burst.
      cam_pend_d    = cam_pend_q | cam_frame_start;
      vga_pend_d    = vga_pend_q | vga_frame_start;
      last_rd_d     = last_rd_q;
      tmo_d         = tmo_q;
      wr_req_d      = wr_req_q;
      rd_req_d      = rd_req_q;
      wr_add_d      = wr_add_q;
      rd_add_d      = rd_add_q;

      case (state_q)
         IDLE: begin
            if (cam_pend_q || vga_pend_q) begin
               // Apply cycle: no grant. A pulse arriving right now stays pending.
               cam_pend_d = cam_frame_start;
               vga_pend_d = vga_frame_start;
               if (cam_pend_q) begin
                  if (wr_blk_q == ROWS_L) begin
                     full_bank_d   = wr_bank_q;
                     wr_bank_d     = ~wr_bank_q;
                     frame_ready_d = 1'b1;
                  end
                  wr_blk_d = '0;
               end
               // Uses full_bank_d so a simultaneous camera start is seen first.
               if (vga_pend_q) begin
                  rd_bank_d = full_bank_d;
                  rd_blk_d  = '0;
               end
            end else if (wr_elig && (!rd_elig || wr_urgent || last_rd_q)) begin
               state_d   = WR_BUSY;
               wr_req_d  = 1'b1;
               wr_add_d  = {1'b0, wr_bank_q, wr_blk_q, 9'd0};
               last_rd_d = 1'b0;
               tmo_d     = '0;
            end else if (rd_elig) begin
               state_d   = RD_BUSY;
               rd_req_d  = 1'b1;
               rd_add_d  = {1'b0, rd_bank_q, rd_blk_q, 9'd0};
               last_rd_d = 1'b1;
               tmo_d     = '0;
            end
         end

         WR_BUSY: begin
            if (bus.wr_sdram_ack) begin
               wr_req_d = 1'b0;
               wr_blk_d = wr_blk_q + 13'd1;
               state_d  = IDLE;
            end else if (tmo_q == TMO_LAST) begin
               wr_req_d  = 1'b0;
               timeout_d = 1'b1;
               state_d   = IDLE;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end

         RD_BUSY: begin
            if (bus.rd_sdram_ack) begin
               rd_req_d = 1'b0;
               rd_blk_d = rd_blk_q + 13'd1;
               state_d  = IDLE;
            end else if (tmo_q == TMO_LAST) begin
               rd_req_d  = 1'b0;
               timeout_d = 1'b1;
               state_d   = IDLE;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end

         default: begin
            state_d  = IDLE;
            wr_req_d = 1'b0;
            rd_req_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_133M_i or negedge rst_133i) begin
      if (!rst_133i) begin
         state_q       <= IDLE;
         wr_blk_q      <= '0;
         rd_blk_q      <= '0;
         wr_bank_q     <= 1'b0;
         rd_bank_q     <= 1'b0;
         full_bank_q   <= 1'b0;
         frame_ready_q <= 1'b0;
         timeout_q     <= 1'b0;
         cam_pend_q    <= 1'b0;
         vga_pend_q    <= 1'b0;
         last_rd_q     <= 1'b1;
         tmo_q         <= '0;
         wr_req_q      <= 1'b0;
         rd_req_q      <= 1'b0;
         wr_add_q      <= '0;
         rd_add_q      <= '0;
      end else begin
         state_q       <= state_d;
         wr_blk_q      <= wr_blk_d;
         rd_blk_q      <= rd_blk_d;
         wr_bank_q     <= wr_bank_d;
         rd_bank_q     <= rd_bank_d;
         full_bank_q   <= full_bank_d;
         frame_ready_q <= frame_ready_d;
         timeout_q     <= timeout_d;
         cam_pend_q    <= cam_pend_d;
         vga_pend_q    <= vga_pend_d;
         last_rd_q     <= last_rd_d;
         tmo_q         <= tmo_d;
         wr_req_q      <= wr_req_d;
         rd_req_q      <= rd_req_d;
         wr_add_q      <= wr_add_d;
         rd_add_q      <= rd_add_d;
      end
   end

   assign bus.wr_sdram_req = wr_req_q;
   assign bus.wr_sdram_add = wr_add_q;
   assign bus.rd_sdram_req = rd_req_q;
   assign bus.rd_sdram_add = rd_add_q;
   assign frame_ready      = frame_ready_q;
   assign wr_bank          = wr_bank_q;
   assign rd_bank          = rd_bank_q;
   assign timeout_err      = timeout_q;

endmodule
